dht_sensor_ctrl: RTL and testbench
==================================

Name: dht_sensor_ctrl

Overview:
Parametrised single-wire humidity/temperature sensor controller, the successor of the team's DHT11-only control unit. Adds a DHT11/DHT22 mode select and an open-drain bus that is never driven high. Adds a per-phase timeout watchdog, a checksum error flag, signed DHT22 temperature decoding and optional periodic auto-trigger. Sits between the button/UART command logic and the FND/UART display path.

Parameters:
CLK_HZ, 100_000_000, system clock frequency; the internal 1 us tick divides by CLK_HZ/1_000_000.
START_LOW_US, 18000, host start pulse low time in us.
BIT_THRESH_US, 50, a high time strictly greater than this decodes as 1, otherwise 0.
TIMEOUT_US, 200, maximum duration of any sensor-driven phase.
AUTO_PERIOD_MS, 2000, auto-trigger period in ms.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
i_start  in  1  single-cycle start request, level-qualified
i_mode  in  1  0 = DHT11, 1 = DHT22; sampled when a transaction is accepted
i_auto_en  in  1  enables periodic auto-trigger
dht_io  inout  1  sensor bus; driven 0 or high-Z only
o_busy  out  1  high whenever state is not IDLE
o_valid  out  1  one-cycle pulse on a good frame
o_err_timeout  out  1  sticky phase-timeout flag
o_err_checksum  out  1  sticky checksum-mismatch flag
o_humidity  out  16  DHT11: integer %RH, zero-extended; DHT22: 0.1 %RH units
o_temperature  out  16  DHT11: integer degC, zero-extended; DHT22: two's-complement 0.1 degC
o_raw  out  40  last received frame, MSB first
o_state  out  4  current state encoding, for debug LEDs

Behaviour:
- Reset: clock is clk; reset is synchronous and active-high on rst. State goes to IDLE and dht_io is released. All outputs are 0. Tick prescaler, auto counter, bit counter and phase counter are cleared.
- dht_io input passes through a 2-flop synchronizer; all decisions use the synchronized value. The resulting ~2-cycle latency is acceptable.
- States, with their o_state encodings: IDLE=0, START=1, REL=2, RESP_L=3, RESP_H=4, BIT_L=5, BIT_H=6, CHECK=7.
- IDLE: bus released. A trigger (i_start, or an auto tick) latches i_mode, clears both error flags and the phase counter, then moves to START. Triggers while busy are ignored. i_start and an auto tick in the same cycle count as one transaction.
- START: drive the bus 0 for START_LOW_US ticks, then release and go to REL.
- REL: wait for the bus to go low, then go to RESP_L.
- RESP_L: wait for high, then go to RESP_H.
- RESP_H: wait for low, then go to BIT_L with the bit counter set to 0.
- BIT_L: wait for high, then go to BIT_H with the phase counter cleared.
- BIT_H: count 1 us ticks while the bus is high. On the falling edge, shift in (count > BIT_THRESH_US). After bit 39, go to CHECK; otherwise return to BIT_L.
- Timeout: the phase counter clears on every state entry. In REL, RESP_L, RESP_H, BIT_L and BIT_H, if the counter reaches TIMEOUT_US, set o_err_timeout and go to IDLE. Data outputs are left unchanged.
- CHECK (1 cycle): sum = (b4+b3+b2+b1) mod 256, compared against b0.
  - On a match: update o_raw, o_humidity and o_temperature, pulse o_valid, go to IDLE.
  - On a mismatch: set o_err_checksum, leave outputs unchanged, go to IDLE.
- DHT22 decode: humidity = {b4,b3}. Temperature magnitude = {b2[6:0],b1}; if b2[7] is set, output the negation of the magnitude.
- DHT11 decode: humidity = {8'h00,b4}; temperature = {8'h00,b2}.
- Auto-trigger: while i_auto_en is high, a ms counter runs and fires a trigger when it reaches AUTO_PERIOD_MS, then restarts. When i_auto_en is low, the counter is held at 0.
- Reset mid-transaction: next cycle state is IDLE and the bus is released. No o_valid pulse is produced.

Optional Feature:
DHT_RETRY_EN
- Defined: on a timeout or checksum error, the controller waits 1000 us with the bus released, then restarts at START. At most 2 retries per trigger.
  - The error flags are only set if the final attempt fails.
  - o_busy stays high across retries.
- Undefined: no retry; the error is reported immediately and the controller returns to IDLE.

Test Plan:
1. DHT11 mode, sensor model sends 0x37,0x00,0x18,0x00,0x4F -> one o_valid pulse, o_humidity=55, o_temperature=24, both error flags 0.
2. DHT22 mode, model sends 0x02,0x8C,0x80,0x65,0x73 -> o_humidity=652, o_temperature=16'hFF9B (-10.1 degC), o_valid pulses.
3. Scenario 1 with the checksum byte changed to 0x50 -> o_err_checksum=1, no o_valid pulse, outputs keep their prior values. With DHT_RETRY_EN and the model repeating the bad frame -> exactly 3 START pulses, then the flag sets.
4. Model never responds -> o_err_timeout=1 exactly TIMEOUT_US after release (within the ±2-cycle synchronizer tolerance), state IDLE, bus high-Z.
5. rst asserted during BIT_H at bit 20 -> next cycle o_state=0, o_busy=0, all outputs 0, bus released. A following i_start completes normally.
6. AUTO_PERIOD_MS=3, i_auto_en=1, good model -> START asserted every 3 ms. i_start pulses during busy are ignored (no extra transactions).

Source files
------------

// File: rtl/dht_sensor_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : dht_sensor_ctrl_if
// Command/status bundle between the command logic and the DHT sensor controller.
// Rev    : 1.0
// ============================================================================
interface dht_sensor_ctrl_if;
    logic        i_start;
    logic        i_mode;
    logic        i_auto_en;
    logic        o_busy;
    logic        o_valid;
    logic        o_err_timeout;
    logic        o_err_checksum;
    logic [15:0] o_humidity;
    logic [15:0] o_temperature;
    logic [39:0] o_raw;
    logic [3:0]  o_state;

    modport master (
        output i_start, i_mode, i_auto_en,
        input  o_busy, o_valid, o_err_timeout, o_err_checksum,
        input  o_humidity, o_temperature, o_raw, o_state
    );

    modport slave (
        input  i_start, i_mode, i_auto_en,
        output o_busy, o_valid, o_err_timeout, o_err_checksum,
        output o_humidity, o_temperature, o_raw, o_state
    );
endinterface
`default_nettype wire

// File: rtl/dht_sensor_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : dht_sensor_ctrl
// DHT11/DHT22 single-wire controller, open-drain bus, watchdog, auto-trigger.
// Option : define DHT_RETRY_EN for up to 2 automatic retries per trigger.
// Rev    : 1.0
// ============================================================================
module dht_sensor_ctrl #(
    parameter int CLK_HZ         = 100_000_000,
    parameter int START_LOW_US   = 18000,
    parameter int BIT_THRESH_US  = 50,
    parameter int TIMEOUT_US     = 200,
    parameter int AUTO_PERIOD_MS = 2000
) (
    input  wire logic        clk,
    input  wire logic        rst,
    dht_sensor_ctrl_if.slave bus,
    inout  wire              dht_io
);
    localparam int c_DIV      = (CLK_HZ / 1_000_000 > 1) ? CLK_HZ / 1_000_000 : 1;
    localparam int c_PRE_W    = (c_DIV > 1) ? $clog2(c_DIV) : 1;
    localparam int c_RETRY_US = 1000;
    localparam int c_PH_MAX0  = (START_LOW_US > TIMEOUT_US) ? START_LOW_US : TIMEOUT_US;
    localparam int c_PH_MAX   = (c_PH_MAX0 > c_RETRY_US) ? c_PH_MAX0 : c_RETRY_US;
    localparam int c_PH_W     = $clog2(c_PH_MAX + 1);
    localparam int c_MS_W     = (AUTO_PERIOD_MS > 1) ? $clog2(AUTO_PERIOD_MS) : 1;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_START  = 4'd1,
        S_REL    = 4'd2,
        S_RESP_L = 4'd3,
        S_RESP_H = 4'd4,
        S_BIT_L  = 4'd5,
        S_BIT_H  = 4'd6,
        S_CHECK  = 4'd7,
        S_WAIT   = 4'd8
    } state_t;

    state_t              state_q;
    logic                drive_low_q;
    logic                sync1_q, sync2_q, sync3_q;
    logic [c_PH_W-1:0]   phase_q;
    logic [5:0]          bit_q;
    logic [39:0]         shift_q;
    logic                mode_q;
    logic                valid_q;
    logic                err_to_q;
    logic                err_ck_q;
    logic [15:0]         hum_q;
    logic [15:0]         temp_q;
    logic [39:0]         raw_q;
`ifdef DHT_RETRY_EN
    logic [1:0]          retry_q;
`endif

    // Free-running 1 us tick
    logic [c_PRE_W-1:0]  pre_q;
    logic                w_tick;
    assign w_tick = (pre_q == c_PRE_W'(c_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || w_tick) pre_q <= '0;
        else               pre_q <= pre_q + 1'b1;
    end

    logic [9:0]          auto_us_q;
    logic [c_MS_W-1:0]   auto_ms_q;
    logic                auto_fire_q;

    always_ff @(posedge clk) begin
        if (rst || !bus.i_auto_en) begin
            auto_us_q   <= '0;
            auto_ms_q   <= '0;
            auto_fire_q <= 1'b0;
        end else begin
            auto_fire_q <= 1'b0;
            if (w_tick) begin
                if (auto_us_q == 10'd999) begin
                    auto_us_q <= '0;
                    if (auto_ms_q == c_MS_W'(AUTO_PERIOD_MS - 1)) begin
                        auto_ms_q   <= '0;
                        auto_fire_q <= 1'b1;
                    end else begin
                        auto_ms_q <= auto_ms_q + 1'b1;
                    end
                end else begin
                    auto_us_q <= auto_us_q + 10'd1;
                end
            end
        end
    end

    logic [7:0]  w_b4, w_b3, w_b2, w_b1, w_b0, w_sum;
    logic [15:0] w_mag, w_hum, w_temp;
    logic        w_watched, w_to_hit, w_ck_bad, w_fail, w_trigger, w_fall;

    assign {w_b4, w_b3, w_b2, w_b1, w_b0} = shift_q;
    assign w_sum  = w_b4 + w_b3 + w_b2 + w_b1;
    assign w_mag  = {1'b0, w_b2[6:0], w_b1};
    assign w_hum  = mode_q ? {w_b4, w_b3} : {8'h00, w_b4};
    assign w_temp = mode_q ? (w_b2[7] ? -w_mag : w_mag) : {8'h00, w_b2};

    assign w_watched = (state_q == S_REL)   || (state_q == S_RESP_L) ||
                       (state_q == S_RESP_H) || (state_q == S_BIT_L) ||
                       (state_q == S_BIT_H);
    assign w_to_hit  = w_watched && (phase_q == c_PH_W'(TIMEOUT_US));
    assign w_ck_bad  = (state_q == S_CHECK) && (w_sum != w_b0);
    assign w_fail    = w_to_hit || w_ck_bad;
    assign w_trigger = bus.i_start || auto_fire_q;
    // Edge detect in REL so the echo of our own start pulse is not taken as the response
    assign w_fall    = sync3_q && !sync2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            drive_low_q <= 1'b0;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            sync3_q     <= 1'b1;
            phase_q     <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            mode_q      <= 1'b0;
            valid_q     <= 1'b0;
            err_to_q    <= 1'b0;
            err_ck_q    <= 1'b0;
            hum_q       <= '0;
            temp_q      <= '0;
            raw_q       <= '0;
`ifdef DHT_RETRY_EN
            retry_q     <= '0;
`endif
        end else begin
            sync1_q <= dht_io;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            valid_q <= 1'b0;
            if (w_tick) phase_q <= phase_q + 1'b1;

            case (state_q)
                S_IDLE: begin
                    phase_q     <= '0;
                    drive_low_q <= 1'b0;
                    if (w_trigger) begin
                        mode_q      <= bus.i_mode;
                        err_to_q    <= 1'b0;
                        err_ck_q    <= 1'b0;
                        drive_low_q <= 1'b1;
                        state_q     <= S_START;
`ifdef DHT_RETRY_EN
                        retry_q     <= '0;
`endif
                    end
                end
                S_START: begin
                    if (phase_q == c_PH_W'(START_LOW_US)) begin
                        drive_low_q <= 1'b0;
                        phase_q     <= '0;
                        state_q     <= S_REL;
                    end
                end
                S_REL: begin
                    if (w_fall) begin
                        phase_q <= '0;
                        state_q <= S_RESP_L;
                    end
                end
                S_RESP_L: begin
                    if (sync2_q) begin
                        phase_q <= '0;
                        state_q <= S_RESP_H;
                    end
                end
                S_RESP_H: begin
                    if (!sync2_q) begin
                        phase_q <= '0;
                        bit_q   <= '0;
                        state_q <= S_BIT_L;
                    end
                end
                S_BIT_L: begin
                    if (sync2_q) begin
                        phase_q <= '0;
                        state_q <= S_BIT_H;
                    end
                end
                S_BIT_H: begin
                    if (!sync2_q) begin
                        shift_q <= {shift_q[38:0], (phase_q > c_PH_W'(BIT_THRESH_US))};
                        phase_q <= '0;
                        if (bit_q == 6'd39) begin
                            state_q <= S_CHECK;
                        end else begin
                            bit_q   <= bit_q + 1'b1;
                            state_q <= S_BIT_L;
                        end
                    end
                end
                S_CHECK: begin
                    phase_q <= '0;
                    state_q <= S_IDLE;
                    if (!w_ck_bad) begin
                        raw_q   <= shift_q;
                        hum_q   <= w_hum;
                        temp_q  <= w_temp;
                        valid_q <= 1'b1;
                    end
                end
`ifdef DHT_RETRY_EN
                S_WAIT: begin
                    if (phase_q == c_PH_W'(c_RETRY_US)) begin
                        phase_q     <= '0;
                        drive_low_q <= 1'b1;
                        state_q     <= S_START;
                    end
                end
`endif
                default: begin
                    drive_low_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase

            // Failures override whatever transition the case above chose
            if (w_fail) begin
                drive_low_q <= 1'b0;
                phase_q     <= '0;
`ifdef DHT_RETRY_EN
                if (retry_q != 2'd2) begin
                    retry_q <= retry_q + 2'd1;
                    state_q <= S_WAIT;
                end else begin
`else
                begin
`endif
                    state_q  <= S_IDLE;
                    err_to_q <= err_to_q | w_to_hit;
                    err_ck_q <= err_ck_q | w_ck_bad;
                end
            end
        end
    end

    assign dht_io             = drive_low_q ? 1'b0 : 1'bz;
    assign bus.o_busy         = (state_q != S_IDLE);
    assign bus.o_valid        = valid_q;
    assign bus.o_err_timeout  = err_to_q;
    assign bus.o_err_checksum = err_ck_q;
    assign bus.o_humidity     = hum_q;
    assign bus.o_temperature  = temp_q;
    assign bus.o_raw          = raw_q;
    assign bus.o_state        = state_q;

endmodule
`default_nettype wire

// File: tb/tb_dht_sensor_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_dht_sensor_ctrl
// Bench for dht_sensor_ctrl: open-drain sensor model plus frame-level reference.
// Rev    : 1.0
// ============================================================================
module tb_dht_sensor_ctrl;
    localparam int c_CLK_HZ         = 2_000_000;
    localparam int c_CLK_NS         = 1_000_000_000 / c_CLK_HZ;
    localparam int c_DIV            = c_CLK_HZ / 1_000_000;
    localparam int c_START_LOW_US   = 40;
    localparam int c_BIT_THRESH_US  = 30;
    localparam int c_TIMEOUT_US     = 100;
    localparam int c_AUTO_PERIOD_MS = 3;
    localparam int c_US             = 1000;
`ifdef DHT_RETRY_EN
    localparam int c_ATTEMPTS       = 3;
`else
    localparam int c_ATTEMPTS       = 1;
`endif

    logic clk      = 1'b0;
    logic rst      = 1'b1;
    logic sens_low = 1'b0;
    wire  dht_io;

    pullup (dht_io);
    assign dht_io = sens_low ? 1'b0 : 1'bz;
    always #(c_CLK_NS / 2) clk = ~clk;

    dht_sensor_ctrl_if bus_if ();

    dht_sensor_ctrl #(
        .CLK_HZ         (c_CLK_HZ),
        .START_LOW_US   (c_START_LOW_US),
        .BIT_THRESH_US  (c_BIT_THRESH_US),
        .TIMEOUT_US     (c_TIMEOUT_US),
        .AUTO_PERIOD_MS (c_AUTO_PERIOD_MS)
    ) u_dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus_if.slave),
        .dht_io (dht_io)
    );

    int          n_total = 0;
    int          n_bad   = 0;
    logic [39:0] model_frame  = '0;
    bit          model_silent = 1'b0;
    bit          model_busy   = 1'b0;
    bit          model_hi     = 1'b0;
    int          model_bit    = -1;
    int          start_cnt    = 0;
    int          valid_cnt    = 0;
    longint      release_t    = 0;
    longint      done_t       = 0;
    longint      start_t[$];
    logic [15:0] exp_hum  = '0;
    logic [15:0] exp_temp = '0;
    logic [39:0] exp_raw  = '0;

    task automatic check_eq(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sensor: answers every host start pulse with the current frame, or stays silent
    initial begin : p_sensor
        #1;
        wait (rst == 1'b0);
        forever begin
            @(negedge dht_io);
            wait (dht_io === 1'b1);
            release_t = $time;
            if (!model_silent) begin
                model_busy = 1'b1;
                #(20 * c_US); sens_low = 1'b1;
                #(40 * c_US); sens_low = 1'b0;
                #(40 * c_US);
                for (int i = 0; i < 40; i++) begin
                    model_bit = i;
                    sens_low  = 1'b1;
                    #(12 * c_US);
                    sens_low  = 1'b0;
                    model_hi  = 1'b1;
                    if (model_frame[39 - i]) #(50 * c_US);
                    else                     #(15 * c_US);
                    model_hi  = 1'b0;
                end
                model_bit = -1;
                sens_low  = 1'b1;
                #(12 * c_US);
                sens_low  = 1'b0;
                model_busy = 1'b0;
            end
        end
    end

    always @(negedge dht_io) begin
        if (!sens_low && !rst) begin
            start_cnt++;
            start_t.push_back($time);
        end
    end

    always @(negedge clk) if (bus_if.o_valid) valid_cnt++;

    task automatic wait_model_idle(input string tag);
        int n = 0;
        while (model_busy && n < 20000) begin @(negedge clk); n++; end
        check_eq({tag, "/model_idle"}, 40'(n < 20000), 40'd1);
    endtask

    // One host transaction plus frame-level expectation of its outcome
    task automatic run_txn(input logic mode, input logic [39:0] frm, input bit silent, input string tag);
        int s0, v0, n, mag, sum;
        logic [7:0] b4, b3, b2, b1, b0;
        bit good;
        model_frame  = frm;
        model_silent = silent;
        s0 = start_cnt;
        v0 = valid_cnt;
        @(negedge clk); bus_if.i_mode = mode; bus_if.i_start = 1'b1;
        @(negedge clk); bus_if.i_start = 1'b0; bus_if.i_mode = ~mode;
        n = 0;
        while (bus_if.o_busy && n < 60000) begin @(negedge clk); n++; end
        done_t = $time;
        check_eq({tag, "/done"}, 40'(n < 60000), 40'd1);
        wait_model_idle(tag);

        {b4, b3, b2, b1, b0} = frm;
        sum  = (int'(b4) + int'(b3) + int'(b2) + int'(b1)) % 256;
        good = !silent && (sum == int'(b0));
        if (good) begin
            exp_raw = frm;
            if (mode) begin
                exp_hum  = 16'(int'(b4) * 256 + int'(b3));
                mag      = int'(b2 & 8'h7f) * 256 + int'(b1);
                exp_temp = b2[7] ? 16'(65536 - mag) : 16'(mag);
            end else begin
                exp_hum  = {8'h00, b4};
                exp_temp = {8'h00, b2};
            end
        end
        check_eq({tag, "/valid_pulses"}, 40'(valid_cnt - v0), good ? 40'd1 : 40'd0);
        check_eq({tag, "/starts"}, 40'(start_cnt - s0), good ? 40'd1 : 40'(c_ATTEMPTS));
        check_eq({tag, "/err_to"}, 40'(bus_if.o_err_timeout), 40'(silent));
        check_eq({tag, "/err_ck"}, 40'(bus_if.o_err_checksum), 40'(!silent && !good));
        check_eq({tag, "/hum"}, 40'(bus_if.o_humidity), 40'(exp_hum));
        check_eq({tag, "/temp"}, 40'(bus_if.o_temperature), 40'(exp_temp));
        check_eq({tag, "/raw"}, bus_if.o_raw, exp_raw);
        check_eq({tag, "/state"}, 40'(bus_if.o_state), 40'd0);
        check_eq({tag, "/bus_rel"}, 40'(dht_io), 40'd1);
    endtask

    initial begin : p_main
        logic [39:0] frm;
        logic [7:0]  r4, r3, r2, r1, rs;
        int n, s0, v0, q0, diff;
        bit pulsed;

        bus_if.i_start   = 1'b0;
        bus_if.i_mode    = 1'b0;
        bus_if.i_auto_en = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("rst/state", 40'(bus_if.o_state), 40'd0);
        check_eq("rst/busy", 40'(bus_if.o_busy), 40'd0);
        check_eq("rst/valid", 40'(bus_if.o_valid), 40'd0);
        check_eq("rst/errs", 40'({bus_if.o_err_timeout, bus_if.o_err_checksum}), 40'd0);
        check_eq("rst/data", {bus_if.o_humidity, bus_if.o_temperature}, 40'd0);
        check_eq("rst/raw", bus_if.o_raw, 40'd0);
        check_eq("rst/bus_rel", 40'(dht_io), 40'd1);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        run_txn(1'b0, 40'h37_00_18_00_4F, 1'b0, "dht11");
        run_txn(1'b1, 40'h02_8C_80_65_73, 1'b0, "dht22");
        run_txn(1'b0, 40'h37_00_18_00_50, 1'b0, "bad_ck");
        run_txn(1'b0, 40'h37_00_18_00_4F, 1'b1, "silent");
        diff = int'((done_t - longint'(c_CLK_NS / 2) - release_t) / c_CLK_NS);
        check_eq("silent/to_latency", 40'(diff >= c_TIMEOUT_US * c_DIV - 3 && diff <= c_TIMEOUT_US * c_DIV + 3), 40'd1);

        // Reset while the sensor is mid-frame
        model_frame  = 40'h37_00_18_00_4F;
        model_silent = 1'b0;
        v0 = valid_cnt;
        @(negedge clk); bus_if.i_mode = 1'b0; bus_if.i_start = 1'b1;
        @(negedge clk); bus_if.i_start = 1'b0;
        n = 0;
        while (!(model_bit == 20 && model_hi) && n < 20000) begin @(negedge clk); n++; end
        check_eq("mid/reach_bit20", 40'(n < 20000), 40'd1);
        repeat (10) @(negedge clk);
        check_eq("mid/state_bit_h", 40'(bus_if.o_state), 40'd6);
        rst = 1'b1;
        @(negedge clk);
        check_eq("mid/state", 40'(bus_if.o_state), 40'd0);
        check_eq("mid/busy", 40'(bus_if.o_busy), 40'd0);
        check_eq("mid/errs", 40'({bus_if.o_valid, bus_if.o_err_timeout, bus_if.o_err_checksum}), 40'd0);
        check_eq("mid/data", {bus_if.o_humidity, bus_if.o_temperature}, 40'd0);
        check_eq("mid/raw", bus_if.o_raw, 40'd0);
        rst = 1'b0;
        exp_hum = '0; exp_temp = '0; exp_raw = '0;
        wait_model_idle("mid");
        check_eq("mid/bus_rel", 40'(dht_io), 40'd1);
        check_eq("mid/no_valid", 40'(valid_cnt - v0), 40'd0);
        run_txn(1'b1, 40'h02_8C_80_65_73, 1'b0, "after_rst");

        for (int k = 0; k < 5; k++) begin
            r4 = 8'($urandom); r3 = 8'($urandom); r2 = 8'($urandom); r1 = 8'($urandom);
            rs = r4 + r3 + r2 + r1;
            if ($urandom_range(0, 3) == 0) rs = rs + 8'($urandom_range(1, 255));
            frm = {r4, r3, r2, r1, rs};
            run_txn(1'($urandom_range(0, 1)), frm, 1'b0, $sformatf("rnd%0d", k));
        end

        // Auto-trigger every AUTO_PERIOD_MS; i_start during busy must not add transactions
        model_frame  = 40'h37_00_18_00_4F;
        model_silent = 1'b0;
        s0 = start_cnt; v0 = valid_cnt; q0 = start_t.size();
        pulsed = 1'b0;
        @(negedge clk);
        bus_if.i_mode    = 1'b0;
        bus_if.i_auto_en = 1'b1;
        for (int c = 0; c < 21000; c++) begin
            @(negedge clk);
            bus_if.i_start = bus_if.o_busy && (model_bit == 10) && !pulsed;
            if (bus_if.i_start) pulsed = 1'b1;
            if (model_bit == -1) pulsed = 1'b0;
        end
        bus_if.i_start   = 1'b0;
        bus_if.i_auto_en = 1'b0;
        n = 0;
        while (bus_if.o_busy && n < 20000) begin @(negedge clk); n++; end
        wait_model_idle("auto");
        exp_hum = 16'd55; exp_temp = 16'd24; exp_raw = 40'h37_00_18_00_4F;
        check_eq("auto/starts", 40'(start_cnt - s0), 40'd3);
        check_eq("auto/valids", 40'(valid_cnt - v0), 40'd3);
        check_eq("auto/hum", 40'(bus_if.o_humidity), 40'(exp_hum));
        check_eq("auto/temp", 40'(bus_if.o_temperature), 40'(exp_temp));
        if (start_t.size() >= q0 + 3) begin
            for (int k = 1; k < 3; k++)
                check_eq($sformatf("auto/period%0d", k), 40'(start_t[q0 + k] - start_t[q0 + k - 1]),
                         40'(c_AUTO_PERIOD_MS * 1_000_000));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
